// File: rtl/sha256_pkg.sv
// Shared SHA-256 helpers for the bit-serial datapath: function select,
// rotate/shift amounts and the combined sigma function.
package sha256_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 5;

    typedef enum logic [1:0] {
        SIG0  = 2'd0,
        SIG1  = 2'd1,
        BSIG0 = 2'd2,
        BSIG1 = 2'd3
    } sigma_func_e;

    localparam int unsigned SIG0_R1  = 7;
    localparam int unsigned SIG0_R2  = 18;
    localparam int unsigned SIG0_S   = 3;
    localparam int unsigned SIG1_R1  = 17;
    localparam int unsigned SIG1_R2  = 19;
    localparam int unsigned SIG1_S   = 10;
    localparam int unsigned BSIG0_R1 = 2;
    localparam int unsigned BSIG0_R2 = 13;
    localparam int unsigned BSIG0_R3 = 22;
    localparam int unsigned BSIG1_R1 = 6;
    localparam int unsigned BSIG1_R2 = 11;
    localparam int unsigned BSIG1_R3 = 25;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] w,
                                               input int unsigned n);
        return (w >> n) | (w << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma(input sigma_func_e func,
                                                input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        case (func)
            SIG0:  r = rotr(w, SIG0_R1) ^ rotr(w, SIG0_R2) ^ (w >> SIG0_S);
            SIG1:  r = rotr(w, SIG1_R1) ^ rotr(w, SIG1_R2) ^ (w >> SIG1_S);
            BSIG0: r = rotr(w, BSIG0_R1) ^ rotr(w, BSIG0_R2) ^ rotr(w, BSIG0_R3);
            BSIG1: r = rotr(w, BSIG1_R1) ^ rotr(w, BSIG1_R2) ^ rotr(w, BSIG1_R3);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_sigma_serial_bclk_edge.sv
// bclk record/play edge detector shared by all bit-serial stages.
// rec/play are single-clk strobes derived from the registered bclk level.
module bclk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    output logic rec,
    output logic play
);

    logic bclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_prev <= 1'b0;
        end else begin
            bclk_prev <= bclk;
        end
    end

    assign rec  = !bclk_prev && bclk;
    assign play = bclk_prev && !bclk;

endmodule

// File: rtl/sha256_sigma_serial.sv
// Bit-serial SHA-256 sigma unit: records a 32-bit LSB-first word and plays
// f(word) during the next word period. Optional SHA256_SIGMA_SYNC_CHECK_EN adds sync_err.
module sha256_sigma_serial
    import sha256_pkg::*;
#(
    parameter int unsigned FUNC = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic in,
    input  logic sof,
    output logic out,
    output logic out_sof,
    output logic out_valid
`ifdef SHA256_SIGMA_SYNC_CHECK_EN
    ,
    output logic sync_err
`endif
);

    localparam sigma_func_e FUNC_SEL = sigma_func_e'(2'(FUNC));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    if (FUNC > 3) begin : g_bad_func
        $error("sha256_sigma_serial: FUNC must be 0..3");
    end

    logic                rec;
    logic                play;
    logic [IDX_W-1:0]    ridx;
    logic [IDX_W-1:0]    pidx;
    logic [WORD_W-2:0]   collect;
    logic [WORD_W-1:0]   result;

    bclk_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bclk  (bclk),
        .rec   (rec),
        .play  (play)
    );

    // Record side: sof always restarts the frame, so a sof on bit 31 suppresses the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ridx      <= '0;
            pidx      <= '0;
            collect   <= '0;
            result    <= '0;
            out       <= 1'b0;
            out_sof   <= 1'b0;
            out_valid <= 1'b0;
        end else if (rec) begin
            if (sof) begin
                collect[0] <= in;
                ridx       <= IDX_W'(1);
            end else if (ridx == LAST_IDX) begin
                result    <= sigma(FUNC_SEL, {in, collect});
                pidx      <= '0;
                out_valid <= 1'b1;
                ridx      <= '0;
            end else begin
                collect[ridx] <= in;
                ridx          <= ridx + IDX_W'(1);
            end
        end else if (play) begin
            out     <= result[pidx];
            out_sof <= out_valid && (pidx == '0);
            pidx    <= pidx + IDX_W'(1);
        end
    end

`ifdef SHA256_SIGMA_SYNC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else if (rec && sof && (ridx != '0)) begin
            sync_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/sha256_sigma_serial.md
# sha256_sigma_serial

Bit-serial SHA-256 sigma unit. It collects one 32-bit word arriving LSB-first on the bit-serial bus and applies one compile-selected SHA-256 rotate/shift function: σ0, σ1, Σ0 or Σ1. The result is streamed out LSB-first during the following word period. It sits between the schedule/state delay lines and the serial adders, using the same clk/bclk record/play scheme. Its output is bit-aligned with a one-word (32-bit) bclk delay line, so it can be summed directly with delayed operands.

## Interface
- FUNC, default 0, selects the function: 0 = σ0 (ROTR7^ROTR18^SHR3), 1 = σ1 (ROTR17^ROTR19^SHR10), 2 = Σ0 (ROTR2^ROTR13^ROTR22), 3 = Σ1 (ROTR6^ROTR11^ROTR25). Any other value is an elaboration error.
- clk  in  1  system clock; all state changes on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- bclk  in  1  bit clock, synchronous to clk, each level held for ≥1 clk.
- in  in  1  serial data, LSB first, sampled on the bclk record edge.
- sof  in  1  start-of-word, sampled with `in`; marks the current bit as bit 0.
- out  out  1  serial result, LSB first, updated on the bclk play edge.
- out_sof  out  1  high while `out` carries bit 0 of a valid result word.
- out_valid  out  1  high once the first complete word has been transferred.
- sync_err  out  1  sticky framing error; present only with SHA256_SIGMA_SYNC_CHECK_EN.

## Operation
- Edge detect: bclk_prev <= bclk every clk. Record edge = !bclk_prev && bclk. Play edge = bclk_prev && !bclk. At most one edge per clk.
- Record edge:
  - collect[ridx] <= in.
  - If sof: collect[0] <= in, ridx <= 1.
  - Otherwise ridx <= ridx+1, wrapping from 31 to 0.
- Transfer, on a record edge with ridx==31 and sof low:
  - result <= f({in, collect[30:0]}).
  - pidx <= 0; out_valid <= 1.
- Play edge:
  - out <= result[pidx]; out_sof <= out_valid && pidx==0.
  - pidx <= pidx+1, wrapping from 31 to 0.
- Framing: sof with ridx==0 is a normal frame. sof with ridx≠0 resynchronises: the partial word is discarded, no transfer occurs, and the previous result keeps playing. With ridx==31, sof wins and no transfer happens.
- Without any sof, ridx free-runs from 0 after reset.
- Arithmetic: ROTR is a 32-bit rotate right; SHR is a logical shift with zero fill; the three terms are XORed bitwise. No carries.

## Timing
- Reset value of every register is 0: out, out_sof, out_valid, sync_err, bclk_prev, ridx, pidx, collect, result.
- Asserting rst_n low mid-word clears everything immediately. After release, the first word is expected at ridx 0.
- Latency: bit 0 of f(word n) appears on `out` at the play edge directly after the record edge of bit 31 of word n. Bit k follows k bclk periods later.
- Word n's output therefore overlaps the recording of word n+1 (one-word delay plus half a bclk).
- Back-to-back words need no gap. result is only replaced at a transfer, so pidx and ridx stay aligned.
- out_valid stays high until reset.

## Configuration
- SHA256_SIGMA_SYNC_CHECK_EN defined:
  - sync_err is set on any sof sampled with ridx≠0 and is cleared only by rst_n.
  - The port exists.
- Macro undefined:
  - No sync_err port or logic.
  - Resynchronisation behaviour is identical.

## Structure
- Shared package sha256_pkg holds:
  - the function-select enum (SIG0, SIG1, BSIG0, BSIG1);
  - the rotate/shift amount constants;
  - a function sigma(func, word) returning the 32-bit result.
- Sub-module bclk_edge (clk, rst_n, bclk → rec, play) is reused by all bit-serial stages.

## Test plan
- FUNC=0, input 0x00000001 with sof on bit 0 → output word 0x02004000, out_sof on its bit 0, out_valid rising at the first transfer.
- FUNC=1, input 0x00000400 → 0x02800001. FUNC=2, input 0x80000000 → 0x20040200. FUNC=3, input 0x00000001 → 0x04200080.
- Four back-to-back words 0x00000001, 0x00000002, 0x00000004, 0x00000008 (FUNC=0), no gaps → outputs 0x02004000, 0x04008000, 0x08010000, 0x10020001, each one word later with no bubbles.
- sof reasserted at ridx=12 mid-word → partial word dropped, previous result keeps playing, then the next full word is processed normally. With the macro, sync_err=1 and stays set.
- rst_n pulsed low at ridx=20 → all outputs read 0 during reset. After release, a new word with sof yields its correct result one word later.
- bclk with unequal duty (high 1 clk, low 5 clk) → same results as the symmetric case, no extra or missing bits.
